// File: rtl/mux_n_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mux_n_arb
//  Purpose  : N-channel registered mux with valid/ready handshakes and a
//             selectable fixed-select / round-robin arbitration mode.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_n_arb #(
    parameter int N  = 3,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           mode,
    input  logic [SW-1:0]  S,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_ch
);

    localparam logic [SW:0]  c_n_chan = (SW + 1)'(N);
    localparam int unsigned  c_n_u    = N;

    logic [SW-1:0] r_ptr;
    logic [SW-1:0] r_out_ch;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_cand_ok;
    logic          w_grant;
    logic          w_rr_found;
    logic [SW-1:0] w_cand;
    logic [SW-1:0] w_rr_idx;
    logic [SW-1:0] w_scan_idx;
    logic [W-1:0]  w_sel_data;

    // Operands never exceed 2N-2, so a single conditional subtract is a full mod N.
    function automatic logic [SW-1:0] f_wrap(input int unsigned v);
        return (v >= c_n_u) ? SW'(v - c_n_u) : SW'(v);
    endfunction

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_scan_idx = f_wrap(32'(r_ptr) + 32'(k));
            if (!w_rr_found && in_valid[w_scan_idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        w_accept  = !r_out_valid || out_ready;
        if (mode) begin
            w_cand    = w_rr_idx;
            w_cand_ok = w_rr_found;
        end else begin
            w_cand    = S;
            w_cand_ok = ({1'b0, S} < c_n_chan);
        end
        w_grant = w_accept && w_cand_ok && in_valid[w_cand];
        // in_ready must stay low through an asserted reset even though accept is high.
        in_ready = '0;
        if (w_grant && reset_n) begin
            in_ready[w_cand] = 1'b1;
        end
    end

    assign w_sel_data = in_data[w_cand * W +: W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_grant) begin
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_cand;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= f_wrap(32'(w_cand) + 32'd1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_n_arb
//  Purpose  : Directed plus randomized self-checking bench for mux_n_arb.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_n_arb;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           mode = 1'b0;
    logic [SW-1:0]  S = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [SW-1:0]  out_ch;

    int checks   = 0;
    int failures = 0;

    // Reference state: the one-entry output buffer and the round-robin pointer.
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_ch;
    int         m_ptr;
    int         g_idx;
    logic [N-1:0] obs_ready;

    bit         ch_v [N];
    logic [W-1:0] ch_d [N];

    always #5 clk = ~clk;

    mux_n_arb #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .S         (S),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    function automatic int model_cand();
        int c;
        c = -1;
        if (!mode) begin
            if (int'(S) < N) c = int'(S);
        end else begin
            for (int k = 0; k < N; k++)
                if (c < 0 && in_valid[(m_ptr + k) % N]) c = (m_ptr + k) % N;
        end
        return c;
    endfunction

    task automatic reset_check();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ch",    32'(out_ch),    32'd0);
        check("rst_ready", 32'(in_ready),  32'd0);
    endtask

    // Entered just after a falling edge with inputs applied; leaves at the next one.
    task automatic cycle();
        int c;
        bit acc;
        logic [N-1:0] er;
        acc   = !m_valid || out_ready;
        c     = model_cand();
        g_idx = (acc && c >= 0 && in_valid[c]) ? c : -1;
        er    = '0;
        if (g_idx >= 0) er[g_idx] = 1'b1;
        #2;
        obs_ready = in_ready;
        check("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (g_idx >= 0) begin
            m_data  = in_data[g_idx * W +: W];
            m_ch    = g_idx;
            m_valid = 1'b1;
            if (mode) m_ptr = (g_idx + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_ch",    32'(out_ch),    32'(m_ch));
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        reset_n   = 1'b1;
        mode      = 1'b1;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        in_data   = {8'h33, 8'h22, 8'h11};
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_check();
        reset_n = 1'b1;
        cycle();
        check("rst_first_ch", 32'(out_ch), 32'd0);

        mode = 1'b0;
        for (int s = 0; s < 3; s++) begin
            S = SW'(s);
            cycle();
            check("fix_data",  32'(out_data),  32'(8'h11 * (s + 1)));
            check("fix_ch",    32'(out_ch),    32'(s));
            check("fix_valid", 32'(out_valid), 32'd1);
        end

        S = 2'd3;
        cycle();
        check("oor_ready", 32'(obs_ready), 32'd0);
        check("oor_valid", 32'(out_valid), 32'd0);
        check("oor_data",  32'(out_data),  32'h33);

        reset_n = 1'b0;
        #1;
        reset_check();
        model_reset();
        @(negedge clk);
        reset_n  = 1'b1;
        mode     = 1'b1;
        in_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr3_ch", 32'(out_ch), 32'(i % 3));
        end
        in_valid = 3'b101;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr2_ch", 32'(out_ch), 32'((i % 2) * 2));
        end

        mode     = 1'b0;
        S        = 2'd1;
        in_valid = 3'b111;
        cycle();
        check("bp_load", 32'(out_data), 32'h22);
        out_ready = 1'b0;
        S         = 2'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_data",  32'(out_data),  32'h22);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(obs_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_next_data",  32'(out_data),  32'h33);
        check("bp_next_valid", 32'(out_valid), 32'd1);

        mode     = 1'b1;
        in_valid = 3'b010;
        cycle();
        check("mid_pre_ch", 32'(out_ch), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        reset_check();
        model_reset();
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 3'b111;
        cycle();
        check("mid_post_ch", 32'(out_ch), 32'd0);

        // Randomized traffic: each channel holds its word until granted.
        for (int c = 0; c < N; c++) ch_v[c] = 1'b0;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!ch_v[c] && $urandom_range(0, 2) != 0) begin
                    ch_v[c] = 1'b1;
                    ch_d[c] = W'($urandom);
                end
                in_valid[c]        = ch_v[c];
                in_data[c * W +: W] = ch_d[c];
            end
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            S         = SW'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (g_idx >= 0) ch_v[g_idx] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_n_arb.md
# mux_n_arb

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and a selectable arbitration mode. It is the next generation of the team's fixed 3:1 select mux. In fixed mode an external select picks the channel. In round-robin mode the block arbitrates fairly among requesting channels. The result is held in a one-entry output register with a channel tag, so it can sit between producer blocks and a shared downstream consumer.

## Interface
Parameters:
- N, default 3: number of input channels, minimum 2.
- W, default 8: data width per channel.
- SW, default $clog2(N): select/tag width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = fixed select via S; 1 = round-robin.
- S  in  SW  channel select, used only when mode=0.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept; at most one bit set (one-hot or zero).
- out_data  out  W  registered selected data.
- out_valid  out  1  out_data/out_ch hold a valid word.
- out_ready  in  1  downstream accept.
- out_ch  out  SW  index of the channel that supplied out_data.

## Operation
- accept = !out_valid || out_ready. This is a one-entry buffer that can refill on the same cycle it drains.
- Fixed mode (mode=0):
  - The candidate channel is S.
  - S >= N selects nothing: no grant, in_ready=0.
- Round-robin mode (mode=1):
  - Search starts at pointer ptr and proceeds ptr, ptr+1, … mod N.
  - The candidate is the first channel with in_valid=1.
- Grant condition: accept && candidate exists && in_valid[candidate].
  - in_ready[candidate]=1 only under this condition; all other bits of in_ready are 0.
- On a grant (rising edge):
  - out_data <= that channel's data.
  - out_ch <= its index.
  - out_valid <= 1.
- Round-robin pointer:
  - In mode 1, a grant sets ptr <= (granted index + 1) mod N, wrapping from N-1 to 0.
  - In mode 0, ptr is unchanged.
  - ptr is kept across mode switches.
- Drain with no new grant: if out_valid && out_ready and no grant, out_valid <= 0. out_data and out_ch keep their last values.
- Stall: out_valid && !out_ready holds out_data/out_ch/out_valid stable and forces in_ready=0.
- Mode or S changes while stalled have no effect on the held word. They take effect at the next accept.
- Upstream must hold in_data/in_valid stable until its in_ready is seen.

## Timing
- Reset (reset_n=0, asynchronous, immediate):
  - out_valid=0, out_data=0, out_ch=0, ptr=0.
  - in_ready is forced to 0 while reset_n=0, regardless of in_valid.
- Latency: 1 cycle. A word granted at edge k appears on out_data with out_valid=1 after edge k.
- Throughput: 1 word/cycle with out_ready held at 1, with no bubble between consecutive words.
- in_ready is combinational from mode, S, in_valid, out_valid, out_ready and ptr. No combinational path from in_data to any output.
- Reset mid-operation: a held word is discarded and ptr returns to 0. After release, the first round-robin search starts at channel 0.

## Test plan
Configuration for all scenarios: N=3, W=8, A/B/C denote channels 0/1/2.

- **Reset:** reset_n=0 with in_valid=3'b111, mode=1 → out_valid=0, out_data=0x00, out_ch=0, in_ready=3'b000. After release with out_ready=1, the first grant is channel 0.
- **Fixed mode (MUX3 equivalence):** A=0x11, B=0x22, C=0x33, all valid, out_ready=1, S=0,1,2 on successive cycles → one cycle later each: out_data=0x11/0x22/0x33, out_ch=0/1/2, out_valid=1 continuously.
- **Out-of-range select:** mode=0, S=3, all valid, with a word pending and out_ready=1 → in_ready=3'b000. After the drain, out_valid=0 and out_data keeps its last value.
- **Round-robin fairness:**
  - mode=1, in_valid=3'b111, out_ready=1 → out_ch sequence 0,1,2,0,1,2.
  - in_valid=3'b101 → out_ch sequence 0,2,0,2. Channel 1 is never granted.
- **Backpressure:** word 0x22 held with out_ready=0 for 3 cycles → out_data=0x22, out_valid=1, in_ready=0 throughout. When out_ready rises, the next grant occurs in that same cycle, with no idle cycle on out_valid.
- **Reset mid-operation:** in round-robin mode with ptr=2 and out_valid=1, pulse reset_n=0 → outputs clear immediately without a clock edge. After release with all channels valid, the first grant is channel 0.
